bridge_gate_guard: RTL and testbench
====================================

# bridge_gate_guard

Downstream stage of the sinusoidal PWM generator. Takes its complementary switching commands (`spwm1`/`spwm2`) and produces the final high-side and low-side gate drives for one inverter half-bridge. Enforces dead-time and shoot-through lockout, and runs an enable / fault-trip / cool-down state machine driven by an external over-current comparator. Everything outside the inverter touches only this block's outputs.

## Interface
- `DT_CYC`, default 20: dead-time in `clk_50m` cycles (400 ns).
- `FAULT_FILT`, default 5: consecutive low samples of synchronized `fault_n` needed to trip.
- `COOL_CYC`, default 50000: cool-down length in cycles (1 ms).
- `clk_50m`  in  1  the single clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  bridge enable, level, synchronous to `clk_50m`.
- `spwm1`  in  1  high-side command from the SPWM generator.
- `spwm2`  in  1  low-side command from the SPWM generator.
- `fault_n`  in  1  over-current comparator, active-low, asynchronous.
- `clr_fault`  in  1  one-cycle pulse that acknowledges a trip.
- `gate_hi`  out  1  high-side gate drive, registered.
- `gate_lo`  out  1  low-side gate drive, registered.
- `tripped`  out  1  high while in TRIP.
- `ovl_err`  out  1  sticky flag: both commands seen high at once.
- `trip_cnt`  out  8  trip counter, saturates at 255.
- `state`  out  2  current state: OFF=0, RUN=1, TRIP=2, COOL=3.

## Operation
**Input synchronization**
- `spwm1`, `spwm2` and `fault_n` each pass through a 2-flop synchronizer; the results are `s1`, `s2` and `f_n`.
- Fault filter counter:
  - increments while `f_n`=0 and saturates at `FAULT_FILT`;
  - clears when `f_n`=1.
- `fault` is asserted while the filter counter equals `FAULT_FILT`.

**Per-leg dead-time (high-side leg shown; low-side is symmetric with `s2` and `gate_hi`)**
- The counter clears when `s1`=0, `gate_lo`=1, `state`≠RUN, or `s1`&`s2`.
- Otherwise it increments and saturates at `DT_CYC`.
- `gate_hi` is set on the cycle after the counter equals `DT_CYC`.
- `gate_hi` is cleared on the cycle after any of the counter's clear conditions holds.

**Overlap handling**
- `s1`&`s2`=1 forces both gates low on the next cycle and sets `ovl_err`.
- `ovl_err` clears only on `clr_fault` or reset.

**State machine (priority within a cycle: fault, then `en`, then `clr_fault`)**
- **OFF**: both gates 0. `en`=1 → RUN.
- **RUN**: gates follow the leg logic. `fault` → TRIP. `en`=0 → OFF.
- **TRIP**: both gates 0; `trip_cnt`+1 on entry, saturating at 255. `clr_fault`=1 with `fault`=0 → COOL. `clr_fault` while `fault`=1 is ignored.
- **COOL**: both gates 0; the counter runs 0..`COOL_CYC`-1.
  - `fault` → TRIP, and `trip_cnt` increments again.
  - At the counter's end: `en`=1 → RUN, `en`=0 → OFF.
  - `en` has no effect before the end.
- Dead-time counters are zero on entry to RUN, so the first edge after enable always waits the full `DT_CYC`.

**Reset values**
- `gate_hi`, `gate_lo`, `tripped`, `ovl_err`: 0.
- `trip_cnt`: 0.
- `state`: OFF.
- All counters and synchronizer flops cleared.
- Reset during RUN or TRIP drops the gates to 0 asynchronously.

## Timing
- Command rise → gate rise: 2 sync + `DT_CYC` + 1 cycles = 23 cycles at defaults, measured when the opposite gate is already low.
- Command fall → gate fall: 3 cycles.
- Complementary handover: the falling gate drops at cycle 3 and the rising gate rises at cycle ≥23. A gap of at least `DT_CYC` cycles is guaranteed.
- Fault:
  - `fault_n` fall → gates 0 and `tripped`=1 in 2 + `FAULT_FILT` + 1 = 8 cycles.
  - Glitches shorter than `FAULT_FILT` cycles after sync are ignored.
- `en` fall in RUN → gates 0 on the next cycle.
- Input pulses shorter than `DT_CYC` produce no gate pulse. This is intended minimum-pulse filtering.

## Structure
- Package `bridge_gate_guard_pkg` holds:
  - the state enum (OFF/RUN/TRIP/COOL, 2 bits);
  - default constants `DT_CYC_DEF`, `FAULT_FILT_DEF`, `COOL_CYC_DEF`.
- Sub-module `dt_leg`, instantiated twice, contains:
  - inputs: own synchronized command, opposite gate, overlap, run;
  - the saturating dead-time counter and a registered gate output.
- Synchronizers, fault filter, state machine and counters live in the top module.

## Test plan
- Enable, square wave `spwm1`=¬`spwm2` at 10 kHz → `gate_hi`/`gate_lo` never high together; each edge gap ≥20 cycles; rise latency 23, fall latency 3.
- `fault_n` low for 4 cycles → no trip. Low for 6 cycles → `state`=TRIP at cycle 8, gates 0, `trip_cnt`=1.
- In TRIP, pulse `clr_fault` while `fault_n`=0 → stays in TRIP. Release, then pulse → COOL for 50000 cycles, then RUN with `en`=1 (or OFF with `en`=0).
- Drive `spwm1`=`spwm2`=1 for 3 cycles → both gates 0, `ovl_err`=1 until `clr_fault`.
- 300 trips → `trip_cnt` holds at 255. Assert `rst_n` mid-RUN → gates 0 immediately, all outputs at reset values.
- 10-cycle `spwm1` pulse in RUN → `gate_hi` stays 0.

Source files
------------

// File: rtl/bridge_gate_guard_pkg.sv
// Shared types and defaults for the half-bridge gate guard.
// Holds the controller state encoding and a counter-width helper.
package bridge_gate_guard_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRIP = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  localparam int DT_CYC_DEF     = 20;
  localparam int FAULT_FILT_DEF = 5;
  localparam int COOL_CYC_DEF   = 50000;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bridge_gate_guard_dt.sv
// One gate leg: saturating dead-time counter and registered gate drive.
// The gate turns on only after the command has been clean for DT_CYC+1 edges.
module dt_leg
  import bridge_gate_guard_pkg::*;
#(
  parameter int DT_CYC = DT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cmd_i,
  input  logic opp_gate_i,
  input  logic ovl_i,
  input  logic run_i,
  output logic gate_o
);

  localparam int CW = cnt_w(DT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DT_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          gate_q, gate_d;
  logic          clr;

  assign clr = !cmd_i || opp_gate_i || ovl_i || !run_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    gate_d = !clr && (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gate_q <= gate_d;
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/bridge_gate_guard.sv
// Final gate-drive stage for one inverter half-bridge: input sync, fault
// filter, enable/trip/cool-down controller and two dead-time legs.
module bridge_gate_guard
  import bridge_gate_guard_pkg::*;
#(
  parameter int DT_CYC     = DT_CYC_DEF,
  parameter int FAULT_FILT = FAULT_FILT_DEF,
  parameter int COOL_CYC   = COOL_CYC_DEF
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       en,
  input  logic       spwm1,
  input  logic       spwm2,
  input  logic       fault_n,
  input  logic       clr_fault,
  output logic       gate_hi,
  output logic       gate_lo,
  output logic       tripped,
  output logic       ovl_err,
  output logic [7:0] trip_cnt,
  output logic [1:0] state
);

  localparam int FW  = cnt_w(FAULT_FILT);
  localparam int CCW = cnt_w(COOL_CYC);
  localparam logic [FW-1:0]  FILT_MAX  = FW'(FAULT_FILT);
  localparam logic [CCW-1:0] COOL_LAST = CCW'(COOL_CYC - 1);

  logic [2:0]     meta_q, sync_q;
  logic           s1, s2, f_n, ovl, fault, run_leg, cool_end;
  logic [FW-1:0]  filt_q, filt_d;
  logic [CCW-1:0] cool_q, cool_d;
  logic [7:0]     trip_cnt_q, trip_cnt_d;
  logic           ovl_err_q, ovl_err_d;
  state_e         state_q, state_d;
  logic [1:0]     leg_cmd, leg_gate;

  assign s1  = sync_q[0];
  assign s2  = sync_q[1];
  assign f_n = sync_q[2];
  assign ovl = s1 && s2;

  assign fault    = (filt_q == FILT_MAX);
  assign cool_end = (cool_q == COOL_LAST);

  always_comb begin
    filt_d = filt_q;
    if (f_n) begin
      filt_d = '0;
    end else if (filt_q != FILT_MAX) begin
      filt_d = filt_q + FW'(1);
    end
  end

  // Fault outranks en, which outranks clr_fault.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (!fault && en) state_d = ST_RUN;
      ST_RUN:  if (fault) state_d = ST_TRIP;
               else if (!en) state_d = ST_OFF;
      ST_TRIP: if (!fault && clr_fault) state_d = ST_COOL;
      ST_COOL: if (fault) state_d = ST_TRIP;
               else if (cool_end) state_d = en ? ST_RUN : ST_OFF;
      default: state_d = ST_OFF;
    endcase
  end

  // Legs count only while RUN holds across the edge, so they start from zero
  // on entry and drop their gates on the same edge that RUN is left.
  assign run_leg = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_comb begin
    cool_d = '0;
    if (state_q == ST_COOL && state_d == ST_COOL) begin
      cool_d = cool_q + CCW'(1);
    end
    trip_cnt_d = trip_cnt_q;
    if (state_d == ST_TRIP && state_q != ST_TRIP && trip_cnt_q != 8'hFF) begin
      trip_cnt_d = trip_cnt_q + 8'd1;
    end
    ovl_err_d = clr_fault ? 1'b0 : (ovl_err_q || ovl);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      filt_q     <= '0;
      cool_q     <= '0;
      trip_cnt_q <= '0;
      ovl_err_q  <= 1'b0;
      state_q    <= ST_OFF;
    end else begin
      meta_q     <= {fault_n, spwm2, spwm1};
      sync_q     <= meta_q;
      filt_q     <= filt_d;
      cool_q     <= cool_d;
      trip_cnt_q <= trip_cnt_d;
      ovl_err_q  <= ovl_err_d;
      state_q    <= state_d;
    end
  end

  assign leg_cmd = {s2, s1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_leg
    dt_leg #(
      .DT_CYC(DT_CYC)
    ) u_leg (
      .clk_i     (clk_50m),
      .rst_ni    (rst_n),
      .cmd_i     (leg_cmd[gi]),
      .opp_gate_i(leg_gate[1-gi]),
      .ovl_i     (ovl),
      .run_i     (run_leg),
      .gate_o    (leg_gate[gi])
    );
  end

  assign gate_hi  = leg_gate[0];
  assign gate_lo  = leg_gate[1];
  assign tripped  = (state_q == ST_TRIP);
  assign ovl_err  = ovl_err_q;
  assign trip_cnt = trip_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_bridge_gate_guard.sv
// Self-checking bench for bridge_gate_guard: directed scenarios plus random
// complementary command streams checked against a windowed dead-time model.
module tb_bridge_gate_guard;

  localparam int DT   = 20;
  localparam int FF   = 5;
  localparam int COOL = 500;
  localparam int NMAX = 4000;

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, spwm1 = 1'b0, spwm2 = 1'b0, fault_n = 1'b1, clr_fault = 1'b0;
  logic       gate_hi, gate_lo, tripped, ovl_err;
  logic [7:0] trip_cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #10 clk_50m = ~clk_50m;

  bridge_gate_guard #(
    .DT_CYC(DT), .FAULT_FILT(FF), .COOL_CYC(COOL)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .en(en), .spwm1(spwm1), .spwm2(spwm2),
    .fault_n(fault_n), .clr_fault(clr_fault), .gate_hi(gate_hi), .gate_lo(gate_lo),
    .tripped(tripped), .ovl_err(ovl_err), .trip_cnt(trip_cnt), .state(state)
  );

  // Inputs change 1 time unit after each rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; spwm1 = 1'b0; spwm2 = 1'b0; fault_n = 1'b1; clr_fault = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; spwm1 = 1'b1; fault_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({gate_hi, gate_lo, tripped, ovl_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b%b%b%b want 0000", gate_hi, gate_lo, tripped, ovl_err);
    end
    checks++;
    if (trip_cnt !== 8'd0) begin errors++; $display("FAIL reset_trip_cnt got %0d want 0", trip_cnt); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    do_reset();
    checks++;
    if (state !== 2'd0 || gate_hi !== 1'b0 || gate_lo !== 1'b0) begin
      errors++; $display("FAIL reset_release state %0d hi %b lo %b want 0 0 0", state, gate_hi, gate_lo);
    end
    $display("test_reset: done");
  endtask

  task automatic test_latency();
    int k;
    do_reset();
    en = 1'b1;
    repeat (5) tick();
    spwm1 = 1'b1;
    k = 0;
    do begin tick(); k++; end while (gate_hi !== 1'b1 && k < 80);
    checks++;
    if (k != DT + 3) begin errors++; $display("FAIL rise_latency got %0d want %0d", k, DT + 3); end
    spwm1 = 1'b0;
    k = 0;
    do begin tick(); k++; end while (gate_hi !== 1'b0 && k < 80);
    checks++;
    if (k != 3) begin errors++; $display("FAIL fall_latency got %0d want 3", k); end
    spwm1 = 1'b1;
    repeat (10) tick();
    spwm1 = 1'b0;
    k = 0;
    repeat (40) begin tick(); if (gate_hi === 1'b1) k++; end
    checks++;
    if (k != 0) begin errors++; $display("FAIL min_pulse got %0d high cycles want 0", k); end
    $display("test_latency: rise/fall/min-pulse measured");
  endtask

  // Gate n is high iff every edge in the last DT+1 edges saw: running, own
  // command high, no overlap, opposite gate low.
  task automatic test_stream(input int ncyc, input bit allow_ovl);
    bit c1 [NMAX];
    bit c2 [NMAX];
    bit eh [NMAX];
    bit el [NMAX];
    bit okh [NMAX];
    bit okl [NMAX];
    bit lvl, ovx, a, b, ph, pl;
    int half, bad;
    lvl = 1'($urandom_range(0, 1));
    half = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (half == 0) begin lvl = !lvl; half = $urandom_range(3, 70); end
      half--;
      c1[n] = lvl; c2[n] = !lvl;
      if ($urandom_range(0, 59) == 0) begin c1[n] = 1'b0; c2[n] = 1'b0; end
      if (allow_ovl && $urandom_range(0, 299) == 0) begin c1[n] = 1'b1; c2[n] = 1'b1; end
    end
    do_reset();
    ovx = 1'b0; bad = 0;
    for (int n = 0; n < ncyc; n++) begin
      en = 1'b1; spwm1 = c1[n]; spwm2 = c2[n];
      tick();
      a  = (n >= 2) ? c1[n-2] : 1'b0;
      b  = (n >= 2) ? c2[n-2] : 1'b0;
      ph = (n >= 1) ? eh[n-1] : 1'b0;
      pl = (n >= 1) ? el[n-1] : 1'b0;
      okh[n] = (n >= 1) && a && !b && !pl;
      okl[n] = (n >= 1) && b && !a && !ph;
      eh[n] = (n >= DT); el[n] = (n >= DT);
      for (int m = n - DT; m <= n; m++) begin
        if (m < 0 || !okh[m]) eh[n] = 1'b0;
        if (m < 0 || !okl[m]) el[n] = 1'b0;
      end
      if (a && b) ovx = 1'b1;
      checks++;
      if (gate_hi !== eh[n] || gate_lo !== el[n]) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL stream_gates cyc %0d got hi=%b lo=%b want hi=%b lo=%b", n, gate_hi, gate_lo, eh[n], el[n]);
      end
      checks++;
      if (ovl_err !== ovx) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL stream_ovl cyc %0d got %b want %b", n, ovl_err, ovx);
      end
    end
    $display("test_stream: %0d cycles ovl_allowed=%0d ovl_seen=%0d", ncyc, allow_ovl, ovx);
  endtask

  task automatic test_fault_filter();
    int first;
    bit gh, gl, tr;
    do_reset();
    en = 1'b1; spwm1 = 1'b1; spwm2 = 1'b0;
    repeat (30) tick();
    checks++;
    if (gate_hi !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL pre_fault_run hi %b state %0d want 1 1", gate_hi, state);
    end
    fault_n = 1'b0;
    repeat (4) tick();
    fault_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (state !== 2'd1 || trip_cnt !== 8'd0) begin
      errors++; $display("FAIL glitch_ignored state %0d trip_cnt %0d want 1 0", state, trip_cnt);
    end
    fault_n = 1'b0;
    first = -1; gh = 1'b1; gl = 1'b1; tr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) fault_n = 1'b1;
      tick();
      if (state === 2'd2 && first < 0) begin first = i + 1; gh = gate_hi; gl = gate_lo; tr = tripped; end
    end
    checks++;
    if (first != FF + 3) begin errors++; $display("FAIL trip_latency got %0d want %0d", first, FF + 3); end
    checks++;
    if (gh !== 1'b0 || gl !== 1'b0 || tr !== 1'b1) begin
      errors++; $display("FAIL trip_outputs hi %b lo %b tripped %b want 0 0 1", gh, gl, tr);
    end
    checks++;
    if (trip_cnt !== 8'd1) begin errors++; $display("FAIL trip_cnt_first got %0d want 1", trip_cnt); end
    $display("test_fault_filter: trip after %0d cycles", first);
  endtask

  task automatic test_clear_cool();
    int cnt, k;
    bit bad;
    fault_n = 1'b0;
    repeat (10) tick();
    clr_fault = 1'b1; tick(); clr_fault = 1'b0; tick();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL clr_during_fault got state %0d want 2", state); end
    fault_n = 1'b1;
    repeat (10) tick();
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL enter_cool got state %0d want 3", state); end
    cnt = 1; bad = 1'b0;
    while (state === 2'd3 && cnt <= 2 * COOL) begin
      if (cnt == 100) en = 1'b0;
      if (cnt == 200) en = 1'b1;
      tick();
      if (gate_hi !== 1'b0 || gate_lo !== 1'b0) bad = 1'b1;
      if (state === 2'd3) cnt++;
    end
    checks++;
    if (cnt != COOL || state !== 2'd1 || bad) begin
      errors++; $display("FAIL cool_to_run len %0d state %0d gates_seen %b want %0d 1 0", cnt, state, bad, COOL);
    end
    k = 1;
    while (gate_hi !== 1'b1 && k < 80) begin tick(); if (gate_hi !== 1'b1) k++; end
    checks++;
    if (k != DT + 1) begin errors++; $display("FAIL run_entry_deadtime got %0d want %0d", k, DT + 1); end
    fault_n = 1'b0;
    k = 0;
    while (state !== 2'd2 && k < 20) begin tick(); k++; end
    fault_n = 1'b1;
    repeat (10) tick();
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    en = 1'b0;
    cnt = 0;
    while (state === 2'd3 && cnt <= 2 * COOL) begin tick(); cnt++; end
    checks++;
    if (cnt != COOL || state !== 2'd0 || trip_cnt !== 8'd2) begin
      errors++; $display("FAIL cool_to_off len %0d state %0d trip_cnt %0d want %0d 0 2", cnt, state, trip_cnt, COOL);
    end
    $display("test_clear_cool: cool length %0d", cnt);
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1; spwm2 = 1'b1;
    repeat (30) tick();
    en = 1'b0;
    tick();
    checks++;
    if (gate_lo !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL en_drop lo %b state %0d want 0 0", gate_lo, state);
    end
    $display("test_en_drop: done");
  endtask

  task automatic test_overlap();
    do_reset();
    en = 1'b1; spwm1 = 1'b1;
    repeat (30) tick();
    spwm2 = 1'b1;
    repeat (3) tick();
    spwm2 = 1'b0;
    checks++;
    if (gate_hi !== 1'b0 || gate_lo !== 1'b0 || ovl_err !== 1'b1) begin
      errors++; $display("FAIL overlap_force hi %b lo %b ovl %b want 0 0 1", gate_hi, gate_lo, ovl_err);
    end
    repeat (30) tick();
    checks++;
    if (ovl_err !== 1'b1) begin errors++; $display("FAIL ovl_sticky got %b want 1", ovl_err); end
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    checks++;
    if (ovl_err !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL ovl_clear ovl %b state %0d want 0 1", ovl_err, state);
    end
    $display("test_overlap: done");
  endtask

  task automatic test_trip_saturate();
    int k, want, bad;
    do_reset();
    en = 1'b1;
    repeat (5) tick();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      fault_n = 1'b0;
      k = 0;
      while (state !== 2'd2 && k < 20) begin tick(); k++; end
      want = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (state !== 2'd2 || trip_cnt !== want[7:0]) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL trip_cnt_sat iter %0d state %0d cnt %0d want 2 %0d", i, state, trip_cnt, want);
      end
      fault_n = 1'b1;
      repeat (6) tick();
      clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    end
    $display("test_trip_saturate: trip_cnt %0d after 300 trips", trip_cnt);
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; spwm2 = 1'b1;
    repeat (30) tick();
    checks++;
    if (gate_lo !== 1'b1) begin errors++; $display("FAIL pre_async_reset lo %b want 1", gate_lo); end
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if ({gate_hi, gate_lo, tripped, ovl_err} !== 4'b0 || state !== 2'd0) begin
      errors++; $display("FAIL async_reset_run flags %b%b%b%b state %0d want 0000 0", gate_hi, gate_lo, tripped, ovl_err, state);
    end
    tick(); rst_n = 1'b1; tick();
    fault_n = 1'b0;
    repeat (15) tick();
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if (tripped !== 1'b0 || trip_cnt !== 8'd0 || state !== 2'd0) begin
      errors++; $display("FAIL async_reset_trip tripped %b cnt %0d state %0d want 0 0 0", tripped, trip_cnt, state);
    end
    fault_n = 1'b1;
    tick(); rst_n = 1'b1; tick();
    $display("test_async_reset: done");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream(3000, 1'b0);
    test_stream(3000, 1'b1);
    test_fault_filter();
    test_clear_cool();
    test_en_drop();
    test_overlap();
    test_trip_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
